// File: rtl/program_sequencer.sv
// Loads each program's data window from the staging RAM into the shared core, then runs it; three programs in turn.
// Optional RUN-state watchdog with per-program error flags when SEQ_TIMEOUT_EN is defined.
module program_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] src_addr,
  input  logic [7:0] src_rdata,
  output logic       core_we,
  output logic [7:0] core_waddr,
  output logic [7:0] core_wdata,
  output logic       core_init,
  input  logic       core_done,
  output logic [1:0] prog_sel,
  output logic       busy,
  output logic       done,
  output logic [2:0] err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE} state_t;

  // Program 2's window is split: byte 6, then 32..95.
  localparam logic [7:0] P1_FIRST  = 8'd1;
  localparam logic [7:0] P1_LAST   = 8'd3;
  localparam logic [7:0] P2_FIRST  = 8'd6;
  localparam logic [7:0] P2_RESUME = 8'd32;
  localparam logic [7:0] P2_LAST   = 8'd95;
  localparam logic [7:0] P3_FIRST  = 8'd128;
  localparam logic [7:0] P3_LAST   = 8'd147;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [1:0] r_prog, w_prog_nxt;
  logic       r_blank, w_blank_nxt;
  logic [7:0] w_last_addr;
  logic       w_accept;
  logic       w_timeout;

  always_comb begin
    case (r_prog)
      2'd2:    w_last_addr = P2_LAST;
      2'd3:    w_last_addr = P3_LAST;
      default: w_last_addr = P1_LAST;
    endcase
  end

  // r_blank masks a done left over from the previous program in the first RUN cycle.
  assign w_accept = (r_state == S_RUN) && core_done && !r_blank;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_prog_nxt  = r_prog;
    w_blank_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_prog_nxt  = 2'd1;
          w_addr_nxt  = P1_FIRST;
        end
      end
      S_LOAD: begin
        if (r_addr == w_last_addr) begin
          w_state_nxt = S_RELEASE;
        end else if ((r_prog == 2'd2) && (r_addr == P2_FIRST)) begin
          w_addr_nxt = P2_RESUME;
        end else begin
          w_addr_nxt = r_addr + 8'd1;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_RUN;
        w_blank_nxt = 1'b1;
      end
      S_RUN: begin
        if (w_accept || w_timeout) begin
          if (r_prog == 2'd3) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
            w_prog_nxt  = r_prog + 2'd1;
            w_addr_nxt  = (r_prog == 2'd1) ? P2_FIRST : P3_FIRST;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_prog  <= '0;
      r_blank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_prog  <= w_prog_nxt;
      r_blank <= w_blank_nxt;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic [2:0]  r_err;
  logic [2:0]  w_err_bit;

  assign w_err_bit = 3'b001 << (r_prog - 2'd1);
  assign w_timeout = (r_state == S_RUN) && (r_wdog == TIMEOUT_CYCLES - 16'd1);

  // A done arriving in the timeout cycle wins, so no error is flagged then.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog <= '0;
      r_err  <= '0;
    end else begin
      if (r_state == S_RUN) r_wdog <= r_wdog + 16'd1;
      else                  r_wdog <= '0;
      if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) r_err <= '0;
      else if (w_timeout && !w_accept)                          r_err <= r_err | w_err_bit;
    end
  end

  assign err = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign err          = 3'b000;
`endif

  assign src_addr   = r_addr;
  assign core_waddr = r_addr;
  assign core_wdata = src_rdata;
  assign core_we    = (r_state == S_LOAD);
  assign core_init  = (r_state == S_LOAD) || (r_state == S_RELEASE);
  assign busy       = (r_state == S_LOAD) || (r_state == S_RELEASE) || (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign prog_sel   = r_prog;

endmodule
